regfile_wb: RTL and testbench

- General-purpose register file sitting at the end of the write-back stage; it is the consumer of the MEM/WB pipeline outputs (wb_wd, wb_wreg, wb_wdata).
- Provides two combinational read ports to the ID stage, with optional same-cycle write-to-read forwarding.
- Provides a registered debug read port with a req/valid handshake.
- Provides a committed-write event counter for performance monitoring.

---
 rtl/regfile_wb.sv | 173 +++++++++++++++++
 tb/tb_regfile_wb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// -----------------------------------------------------------------------------
// regfile_wb
// General-purpose register file at the end of the write-back stage.
// It takes the MEM/WB outputs (wb_wreg -> we, wb_wd -> waddr, wb_wdata -> wdata)
// and serves the ID stage through two combinational read ports. It also has a
// registered debug read port and a committed-write event counter.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : read ports forward wdata when the same nonzero address is being
//               written in the same cycle (zero-delay WB-to-ID hazard resolution).
//   undefined : read ports return the pre-write array contents; the new value
//               is visible from the cycle after the write edge.
//   The debug port is write-first in both builds.
//
// Ports:
//   clk        in   1       system clock, all state updates on rising edge
//   rst        in   1       asynchronous active-high reset
//   we         in   1       write enable
//   waddr      in   ADDR_W  write address (address 0 is ignored)
//   wdata      in   DATA_W  write data
//   re1/re2    in   1       read port enables
//   raddr1/2   in   ADDR_W  read port addresses
//   rdata1/2   out  DATA_W  read port data (combinational)
//   dbg_req    in   1       debug read request (pulse or held high)
//   dbg_addr   in   ADDR_W  debug read address
//   dbg_valid  out  1       debug data valid (registered, 1-cycle latency)
//   dbg_data   out  DATA_W  debug read data (registered, holds when idle)
//   wr_count   out  CNT_W   committed-write counter (registered, wraps)
//
// NUM_REGS must equal 2**ADDR_W so that every address maps to an entry.
// -----------------------------------------------------------------------------
module regfile_wb #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Storage. Entry 0 is never written, so it stays at its reset value of 0.
    logic [DATA_W-1:0] entry_r [NUM_REGS];
    logic              dbg_valid_r;
    logic [DATA_W-1:0] dbg_data_r;
    logic [CNT_W-1:0]  wr_count_r;

    // Qualified write: address 0 is hardwired to zero and never commits.
    logic              commit_s;
    logic              fwd1_s;
    logic              fwd2_s;
    logic [DATA_W-1:0] dbg_next_s;

    // Resolve one read port in priority order: reset, enable, address 0,
    // same-cycle forward, array contents.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_in,
        input logic              ren,
        input logic [ADDR_W-1:0] ra,
        input logic              fwd,
        input logic [DATA_W-1:0] fwd_data,
        input logic [DATA_W-1:0] array_data
    );
        logic [DATA_W-1:0] res;
        if (rst_in) begin
            res = ZERO_DATA;
        end else if (!ren) begin
            res = ZERO_DATA;
        end else if (ra == ZERO_ADDR) begin
            res = ZERO_DATA;
        end else if (fwd) begin
            res = fwd_data;
        end else begin
            res = array_data;
        end
        return res;
    endfunction

    // Write qualification shared by array update and counter.
    always_comb begin
        commit_s = we && (waddr != ZERO_ADDR);
    end

    // Forwarding hit detection; tied off when bypass is not built in.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        fwd1_s = we && (waddr == raddr1);
        fwd2_s = we && (waddr == raddr2);
`else
        fwd1_s = 1'b0;
        fwd2_s = 1'b0;
`endif
    end

    // Combinational read ports for the ID stage.
    always_comb begin
        rdata1 = read_port(rst, re1, raddr1, fwd1_s, wdata, entry_r[raddr1]);
        rdata2 = read_port(rst, re2, raddr2, fwd2_s, wdata, entry_r[raddr2]);
    end

    // Debug lookup is always write-first so the captured value matches what
    // the array holds after this edge.
    always_comb begin
        if (dbg_addr == ZERO_ADDR) begin
            dbg_next_s = ZERO_DATA;
        end else if (we && (waddr == dbg_addr)) begin
            dbg_next_s = wdata;
        end else begin
            dbg_next_s = entry_r[dbg_addr];
        end
    end

    // Register array update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                entry_r[i] <= ZERO_DATA;
            end
        end else if (commit_s) begin
            entry_r[waddr] <= wdata;
        end else begin
            entry_r[waddr] <= entry_r[waddr];
        end
    end

    // Committed-write counter; wraps silently at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_r <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            wr_count_r <= wr_count_r + CNT_ONE;
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    // Debug read port: one result per requesting cycle, data held when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_valid_r <= 1'b0;
            dbg_data_r  <= ZERO_DATA;
        end else if (dbg_req) begin
            dbg_valid_r <= 1'b1;
            dbg_data_r  <= dbg_next_s;
        end else begin
            dbg_valid_r <= 1'b0;
            dbg_data_r  <= dbg_data_r;
        end
    end

    assign dbg_valid = dbg_valid_r;
    assign dbg_data  = dbg_data_r;
    assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_regfile_wb.sv
`timescale 1ns/1ps
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic [3:0]  wr_count;

    int passed;
    int total;
    int exp_cnt;
    logic [31:0] exp_hazard;

    regfile_wb #(
        .NUM_REGS(32),
        .ADDR_W  (5),
        .DATA_W  (32),
        .CNT_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_valid(dbg_valid),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
`ifdef REGFILE_BYPASS_EN
        exp_hazard = 32'h22222222;
`else
        exp_hazard = 32'h11111111;
`endif
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
        dbg_req = 1'b0; dbg_addr = 5'd0;
        repeat (2) @(negedge clk);

        // Reset state
        rst = 1'b0; re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd3; raddr2 = 5'd31;
        #1;
        check("reset_rdata1", rdata1, 32'd0);
        check("reset_rdata2", rdata2, 32'd0);
        check("reset_wr_count", {28'd0, wr_count}, 32'd0);
        check("reset_dbg_valid", {31'd0, dbg_valid}, 32'd0);
        check("reset_dbg_data", dbg_data, 32'd0);

        // Basic write then read
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        @(negedge clk);
        we = 1'b0; raddr1 = 5'd5;
        #1;
        check("write5_rdata1", rdata1, 32'hDEADBEEF);
        check("write5_wr_count", {28'd0, wr_count}, 32'd1);

        // Write to address 0 is ignored, even in the write cycle
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
        #1;
        check("addr0_same_cycle", rdata1, 32'd0);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("addr0_rdata1", rdata1, 32'd0);
        check("addr0_wr_count", {28'd0, wr_count}, 32'd1);

        // Same-cycle hazard on address 7
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h22222222; raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        check("hazard_rdata1", rdata1, exp_hazard);
        check("hazard_rdata2", rdata2, exp_hazard);
        check("hazard_wr_count", {28'd0, wr_count}, 32'd2);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("hazard_next_rdata1", rdata1, 32'h22222222);
        check("hazard_next_rdata2", rdata2, 32'h22222222);
        check("hazard_next_wr_count", {28'd0, wr_count}, 32'd3);

        // Read enable gating
        re2 = 1'b0; raddr2 = 5'd5; raddr1 = 5'd5;
        #1;
        check("re2_gated", rdata2, 32'd0);
        check("re1_same_addr", rdata1, 32'hDEADBEEF);
        re2 = 1'b1;

        // Single debug pulse, then data holds with valid low
        @(negedge clk);
        dbg_req = 1'b1; dbg_addr = 5'd5;
        @(negedge clk);
        dbg_req = 1'b0;
        #1;
        check("dbg1_valid", {31'd0, dbg_valid}, 32'd1);
        check("dbg1_data", dbg_data, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        check("dbg1_valid_drop", {31'd0, dbg_valid}, 32'd0);
        check("dbg1_data_hold", dbg_data, 32'hDEADBEEF);

        // Debug read coinciding with a write to the same address
        @(negedge clk);
        dbg_req = 1'b1; dbg_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h5A5A5A5A;
        @(negedge clk);
        dbg_req = 1'b0; we = 1'b0;
        #1;
        check("dbg_wf_valid", {31'd0, dbg_valid}, 32'd1);
        check("dbg_wf_data", dbg_data, 32'h5A5A5A5A);
        check("dbg_wf_wr_count", {28'd0, wr_count}, 32'd4);

        // Back-to-back debug requests: 5, 7, 9, then 0
        @(negedge clk);
        dbg_req = 1'b1; dbg_addr = 5'd5;
        @(negedge clk);
        dbg_addr = 5'd7;
        #1;
        check("b2b0_valid", {31'd0, dbg_valid}, 32'd1);
        check("b2b0_data", dbg_data, 32'hDEADBEEF);
        @(negedge clk);
        dbg_addr = 5'd9;
        #1;
        check("b2b1_valid", {31'd0, dbg_valid}, 32'd1);
        check("b2b1_data", dbg_data, 32'h22222222);
        @(negedge clk);
        dbg_addr = 5'd0;
        #1;
        check("b2b2_valid", {31'd0, dbg_valid}, 32'd1);
        check("b2b2_data", dbg_data, 32'h5A5A5A5A);
        @(negedge clk);
        dbg_req = 1'b0;
        #1;
        check("b2b3_valid", {31'd0, dbg_valid}, 32'd1);
        check("b2b3_addr0_data", dbg_data, 32'd0);
        @(negedge clk);
        #1;
        check("b2b_end_valid", {31'd0, dbg_valid}, 32'd0);

        // Counter wrap: 17 nonzero writes starting from count 4 (4-bit counter)
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            we = 1'b1; waddr = 5'(k); wdata = 32'h01000000 * k + 32'h00000055;
            @(negedge clk);
            we = 1'b0;
            #1;
            exp_cnt = (4 + k) % 16;
            check($sformatf("wrap_cnt_%0d", k), {28'd0, wr_count}, 32'(exp_cnt));
        end
        raddr1 = 5'd17;
        #1;
        check("wrap_readback17", rdata1, 32'h11000055);

        // Async reset mid-cycle: outputs clear without a clock edge
        @(negedge clk);
        dbg_req = 1'b1; dbg_addr = 5'd17;
        @(posedge clk);
        #3;
        rst = 1'b1; raddr1 = 5'd17;
        #1;
        check("async_rdata1", rdata1, 32'd0);
        check("async_wr_count", {28'd0, wr_count}, 32'd0);
        check("async_dbg_valid", {31'd0, dbg_valid}, 32'd0);
        check("async_dbg_data", dbg_data, 32'd0);

        // Write presented while in reset is discarded
        dbg_req = 1'b0; we = 1'b1; waddr = 5'd17; wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        #1;
        check("post_rst_rdata1", rdata1, 32'd0);
        check("post_rst_wr_count", {28'd0, wr_count}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
